multi_line_buffer: RTL and testbench

MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

---
 rtl/conv_pkg.sv | 21 ++
 rtl/mlb_ram.sv | 34 +++
 rtl/multi_line_buffer.sv | 126 ++++++++++++
 tb/tb_multi_line_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the line-buffer blocks: address sizing, lane slicing
// and the runtime line-length clamp.
package conv_pkg;

    // Lane that receives the newest sample; older lanes sit above it.
    localparam int NEW_LANE = 0;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // A zero or oversized length means "use the full storage depth".
    function automatic int clamp_len(input int len, input int max_depth);
        return (len == 0 || len > max_depth) ? max_depth : len;
    endfunction

endpackage

// File: rtl/mlb_ram.sv
// Single-port column store for multi_line_buffer: read-first, one registered
// read, no reset. Each access shifts the addressed word up one lane.
module mlb_ram
    import conv_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic                         i_clk,
    input  logic                         en,
    input  logic [addr_width(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]             shift_in,
    output logic [LANES*WIDTH-1:0]       rdata
);

    logic [LANES*WIDTH-1:0] mem [DEPTH];
    logic [LANES*WIDTH-1:0] word_old;
    logic [LANES*WIDTH-1:0] word_new;

    always_comb begin
        word_old = mem[addr];
        word_new = word_old << WIDTH;
        word_new[lane_lsb(NEW_LANE, WIDTH) +: WIDTH] = shift_in;
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            rdata     <= word_old;
            mem[addr] <= word_new;
        end
    end

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-line buffer: delivers, per written column, the samples of the previous
// LINES lines. Define MLB_ZERO_PAD_EN for top-edge zero padding from line 0.
module multi_line_buffer
    import conv_pkg::*;
#(
    parameter int MAX_DEPTH = 1024,
    parameter int WIDTH     = 8,
    parameter int LINES     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_resetn,
    input  logic                         i_sof,
    input  logic [$clog2(MAX_DEPTH):0]   i_line_len,
    input  logic                         i_wr_valid,
    input  logic [WIDTH-1:0]             i_wr_data,
    output logic                         o_rd_valid,
    output logic [LINES*WIDTH-1:0]       o_rd_data,
    output logic [$clog2(MAX_DEPTH)-1:0] o_col
);

    localparam int AW  = addr_width(MAX_DEPTH);
    localparam int LW  = AW + 1;
    localparam int LDW = $clog2(LINES + 1);

    logic [LW-1:0]          len_q;
    logic [LW-1:0]          len_eff;
    logic [AW-1:0]          col_q;
    logic [AW-1:0]          col_eff;
    logic [AW-1:0]          col_next;
    logic [LDW-1:0]         ld_q;
    logic [LDW-1:0]         ld_eff;
    logic [LDW-1:0]         ld_next;
    logic                   wrap;
    logic                   out_valid;
    logic [LINES*WIDTH-1:0] ram_q;

    // A start-of-frame restarts the counters in the same cycle, so the
    // qualifying sample is already column 0 of line 0 under the new length.
    always_comb begin
        len_eff = len_q;
        col_eff = col_q;
        ld_eff  = ld_q;
        if (i_sof) begin
            len_eff = LW'(clamp_len(int'(i_line_len), MAX_DEPTH));
            col_eff = '0;
            ld_eff  = '0;
        end
        wrap     = ({1'b0, col_eff} == (len_eff - LW'(1)));
        col_next = col_eff;
        ld_next  = ld_eff;
        if (i_wr_valid) begin
            col_next = wrap ? '0 : col_eff + AW'(1);
            if (wrap && ld_eff != LDW'(LINES))
                ld_next = ld_eff + LDW'(1);
        end
    end

    mlb_ram #(
        .DEPTH (MAX_DEPTH),
        .WIDTH (WIDTH),
        .LANES (LINES)
    ) u_ram (
        .i_clk    (i_clk),
        .en       (i_wr_valid),
        .addr     (col_eff),
        .shift_in (i_wr_data),
        .rdata    (ram_q)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            len_q      <= LW'(MAX_DEPTH);
            col_q      <= '0;
            ld_q       <= '0;
            o_rd_valid <= 1'b0;
            o_col      <= '0;
        end else begin
            len_q      <= len_eff;
            col_q      <= col_next;
            ld_q       <= ld_next;
            o_rd_valid <= out_valid;
            if (i_wr_valid)
                o_col <= col_eff;
        end
    end

`ifdef MLB_ZERO_PAD_EN
    logic [LINES*WIDTH-1:0] lane_mask;
    logic [LINES*WIDTH-1:0] out_mask;

    // Lanes reaching above the first line of the frame read as zero.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LINES; k++)
            if (k < int'(ld_eff))
                lane_mask[lane_lsb(k, WIDTH) +: WIDTH] = '1;
    end

    assign out_valid = i_wr_valid;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            out_mask <= '0;
        else if (i_wr_valid)
            out_mask <= lane_mask;
    end

    assign o_rd_data = ram_q & out_mask;
`else
    logic rd_live;

    assign out_valid = i_wr_valid && (ld_eff == LDW'(LINES));

    // The store itself has no reset, so the output reads zero until the
    // first post-reset write refreshes the read register.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            rd_live <= 1'b0;
        else if (i_wr_valid)
            rd_live <= 1'b1;
    end

    assign o_rd_data = rd_live ? ram_q : '0;
`endif

endmodule

// File: tb/tb_multi_line_buffer.sv
// Self-checking bench for multi_line_buffer (MAX_DEPTH=8, WIDTH=8, LINES=2),
// directed scenarios followed by randomized traffic against a column-history model.
module tb_multi_line_buffer;

    localparam int MD = 8;
    localparam int W  = 8;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sof = 1'b0;
    logic [3:0]    line_len = '0;
    logic          wv = 1'b0;
    logic [W-1:0]  wd = '0;
    logic          rd_valid;
    logic [L*W-1:0] rd_data;
    logic [2:0]    col;

    int checks = 0;
    int failures = 0;

`ifdef MLB_ZERO_PAD_EN
    bit zero_pad = 1'b1;
`else
    bit zero_pad = 1'b0;
`endif

    // Reference model: frame geometry plus every sample ever written per column.
    int             m_len;
    int             m_col;
    int             m_line;
    logic [W-1:0]   hist [MD][$];
    logic           exp_valid;
    logic [L*W-1:0] exp_data;
    logic           exp_data_known;
    logic [2:0]     exp_col;

    multi_line_buffer #(
        .MAX_DEPTH (MD),
        .WIDTH     (W),
        .LINES     (L)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_sof      (sof),
        .i_line_len (line_len),
        .i_wr_valid (wv),
        .i_wr_data  (wd),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_col      (col)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_len          = MD;
        m_col          = 0;
        m_line         = 0;
        exp_valid      = 1'b0;
        exp_data       = '0;
        exp_data_known = 1'b1;
        exp_col        = '0;
    endtask

    task automatic modelStep(input bit s, input int ll, input bit v, input int d);
        int ld;
        int n;
        if (s) begin
            m_len  = (ll == 0 || ll > MD) ? MD : ll;
            m_col  = 0;
            m_line = 0;
        end
        exp_valid = 1'b0;
        if (v) begin
            ld = (m_line < L) ? m_line : L;
            exp_valid      = zero_pad || (m_line >= L);
            exp_col        = 3'(m_col);
            exp_data_known = 1'b1;
            n = hist[m_col].size();
            for (int k = 0; k < L; k++) begin
                if (zero_pad && k >= ld)
                    exp_data[k*W +: W] = '0;
                else if (n > k)
                    exp_data[k*W +: W] = hist[m_col][n-1-k];
                else
                    exp_data_known = 1'b0;
            end
            hist[m_col].push_back(W'(d));
            if (hist[m_col].size() > L)
                void'(hist[m_col].pop_front());
            m_col++;
            if (m_col == m_len) begin
                m_col = 0;
                m_line++;
            end
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks its result.
    task automatic applyStimulus(input bit s, input int ll, input bit v, input int d);
        sof      = s;
        line_len = 4'(ll);
        wv       = v;
        wd       = W'(d);
        modelStep(s, ll, v, d);
        @(posedge clk);
        #1;
        checkOutput("valid", 32'(rd_valid), 32'(exp_valid));
        checkOutput("col", 32'(col), 32'(exp_col));
        if (exp_data_known)
            checkOutput("data", 32'(rd_data), 32'(exp_data));
    endtask

    // Back-to-back writes, the first one carrying sof; reports the first
    // write index that produced o_rd_valid and the column seen at 'probe'.
    task automatic runWrites(input int ll, input int n, input int base, input int probe,
                             output int first, output logic [2:0] probe_col);
        first     = 0;
        probe_col = '0;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(i == 1, ll, 1'b1, base + i);
            if (rd_valid && first == 0)
                first = i;
            if (i == probe)
                probe_col = col;
        end
    endtask

    task automatic pulseReset();
        sof = 1'b0;
        wv  = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_data", 32'(rd_data), 32'd0);
        checkOutput("rst_col", 32'(col), 32'd0);
        modelReset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first;
        logic [2:0] pcol;

        modelReset();
        #1;
        checkOutput("init_valid", 32'(rd_valid), 32'd0);
        checkOutput("init_data", 32'(rd_data), 32'd0);
        checkOutput("init_col", 32'(col), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

`ifdef MLB_ZERO_PAD_EN
        applyStimulus(1'b1, 4, 1'b1, 7);
        checkOutput("zp_first_valid", 32'(rd_valid), 32'd1);
        checkOutput("zp_first_data", 32'(rd_data), 32'd0);
        for (int i = 2; i <= 4; i++)
            applyStimulus(1'b0, 0, 1'b1, 7 + i);
        applyStimulus(1'b0, 0, 1'b1, 20);
        checkOutput("zp_line1_data", 32'(rd_data), 32'h0007);
`endif

        // Fill: len 4, first valid column after the 9th sample.
        runWrites(4, 9, 0, 9, first, pcol);
        checkOutput("fill_first", 32'(first), zero_pad ? 32'd1 : 32'd9);
        checkOutput("fill_data", 32'(rd_data), 32'h0105);
        checkOutput("fill_col", 32'(pcol), 32'd0);
        for (int i = 10; i <= 12; i++)
            applyStimulus(1'b0, 0, 1'b1, i);

        // Runtime length change to 3.
        runWrites(3, 9, 100, 4, first, pcol);
        checkOutput("len3_first", 32'(first), zero_pad ? 32'd1 : 32'd7);
        checkOutput("len3_wrap_col", 32'(pcol), 32'd0);

        // Clamping of 0 and oversized lengths.
        runWrites(0, 17, 150, 9, first, pcol);
        checkOutput("clamp0_first", 32'(first), zero_pad ? 32'd1 : 32'd17);
        checkOutput("clamp0_wrap_col", 32'(pcol), 32'd0);
        runWrites(9, 17, 50, 8, first, pcol);
        checkOutput("clamp9_first", 32'(first), zero_pad ? 32'd1 : 32'd17);
        checkOutput("clamp9_last_col", 32'(pcol), 32'd7);

        // sof on the 3rd write of line 2.
        runWrites(4, 10, 200, 0, first, pcol);
        runWrites(4, 9, 220, 9, first, pcol);
        checkOutput("midsof_first", 32'(first), zero_pad ? 32'd1 : 32'd9);
        checkOutput("midsof_col", 32'(pcol), 32'd0);

        // Asynchronous reset mid-frame, then refill.
        runWrites(4, 11, 30, 0, first, pcol);
        pulseReset();
        runWrites(4, 9, 60, 9, first, pcol);
        checkOutput("refill_first", 32'(first), zero_pad ? 32'd1 : 32'd9);

        // Outputs hold across idle and sof-only cycles.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 0, 1'b0, 0);
        applyStimulus(1'b1, 5, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 77);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0)
                pulseReset();
            else
                applyStimulus($urandom_range(0, 39) == 0, int'($urandom_range(0, 9)),
                              $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
